serial_bit_xform: RTL and testbench
===================================

# serial_bit_xform

Parametrised, sequential successor to the 8-bit combinational x→y transform: it accepts a WIDTH-bit operand with a start/busy/done handshake and computes one of four selectable bit transforms, one bit per clock. It sits as a shared arithmetic/encoding engine between the stimulus source and the result register bank. Bit-serial evaluation keeps the area flat as WIDTH grows.

## Interface
- WIDTH, 8: operand and result width in bits; legal range 1–64.
- CNT_W, $clog2(WIDTH+1): bit-counter width; derived, never overridden.
- clk  in  1  single system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- mode  in  2  transform select, sampled with start: 0 = binary→Gray, 1 = Gray→binary, 2 = bit-reverse, 3 = two's-complement negate.
- x  in  WIDTH  operand, sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when y is updated.
- y  out  WIDTH  result register; holds its value until the next done.
- parity  out  1  present only with XFORM_PARITY_EN; see Configuration.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 latches x and mode into an operand register, clears cnt, sets carry=1, and moves to RUN.
  - RUN: processes one bit per cycle; after WIDTH cycles moves to DONE.
  - DONE: if start=1, latches new operands and returns to RUN back-to-back; otherwise moves to IDLE.
- Bit index i: MSB-first (i = WIDTH-1-cnt) for mode 1; LSB-first (i = cnt) for all other modes.
- Per-bit rules, with w = the working result register:
  - Mode 0: w[i] = x[i] ^ x[i+1]; x[WIDTH] is treated as 0.
  - Mode 1: w[i] = x[i] ^ w[i+1]; w[WIDTH] is treated as 0.
  - Mode 2: w[i] = x[WIDTH-1-i].
  - Mode 3: w[i] = ~x[i] ^ carry; carry ← ~x[i] & carry. Negating the most negative value returns the same value; no overflow flag.
- On the RUN→DONE edge, w is copied into y. y never shows partial results.
- start while in RUN is ignored. No queueing; the requester retries after done.
- Reset, including reset mid-RUN, aborts any operation. State goes to IDLE; y, w, cnt, busy, done and parity go to 0; carry goes to 1.

## Timing
- start sampled at edge t: busy=1 during cycles t+1 … t+WIDTH; done=1 and new y visible in cycle t+WIDTH+1.
- Latency is WIDTH+1 cycles. Back-to-back throughput is one result per WIDTH+1 cycles.
- WIDTH=1: RUN lasts exactly one cycle; the same rules apply.
- busy and done are registered and are never high in the same cycle.

## Configuration
- XFORM_PARITY_EN defined:
  - Adds a registered parity output equal to the XOR-reduce of the new y.
  - parity updates in the same cycle as done and holds with y.
  - parity is 0 after reset.
- XFORM_PARITY_EN undefined: the parity port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package xform_pkg holds:
  - the mode encoding constants (XF_BIN2GRAY, XF_GRAY2BIN, XF_REVERSE, XF_NEGATE);
  - the state encoding (S_IDLE, S_RUN, S_DONE).
- One combinational sub-module, xform_bit_slice:
  - inputs: mode, x[i], x_nb (x[i+1] or x[WIDTH-1-i] as applicable), w_prev, carry_in;
  - outputs: w_bit, carry_out.
- The top level owns the FSM, counter, index mux and registers.

## Test plan
All scenarios use WIDTH=8 unless stated.
- Reset: rst=1 for 2 cycles, then release → y=0, busy=0, done=0, state IDLE; stays idle with start=0.
- Mode 0, x=8'b10101011, start for one cycle → busy high 8 cycles, done in cycle 9, y=8'b11111110 (parity=1 if enabled).
- Mode 1, x=8'b10101011 → y=8'b11001101. Then mode 2, same x → y=8'b11010101. y must hold between done pulses.
- Mode 3, x=8'b10101011 → y=8'b01010101. Also x=8'h80 → y=8'h80, and x=0 → y=0.
- Handshake corners:
  - start held high continuously → results every 9 cycles with fresh operands;
  - start pulsed mid-RUN → ignored, y unchanged from the first result;
  - rst asserted at RUN cycle 4 → y=0, no done pulse.
- WIDTH=1 instance:
  - mode 3, x=1 → y=1 after 2 cycles;
  - mode 0, x=1 → y=1.

Source files
------------

// File: rtl/xform_pkg.sv
// ---------------------------------------------------------------------------
// xform_pkg
// Shared definitions for the serial bit-transform engine.
//   xform_mode_e : transform select encoding (the 2-bit mode field)
//   state_e      : control FSM state encoding (IDLE -> RUN -> DONE)
// Optional feature macro used across the slice: XFORM_PARITY_EN
// ---------------------------------------------------------------------------
package xform_pkg;

  typedef enum logic [1:0] {
    XF_BIN2GRAY = 2'd0,  // w[i] = x[i] ^ x[i+1], LSB-first
    XF_GRAY2BIN = 2'd1,  // w[i] = x[i] ^ w[i+1], MSB-first
    XF_REVERSE  = 2'd2,  // w[i] = x[WIDTH-1-i], LSB-first
    XF_NEGATE   = 2'd3   // two's-complement negate, LSB-first ripple carry
  } xform_mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage : xform_pkg

// File: rtl/serial_bit_xform_if.sv
// ---------------------------------------------------------------------------
// serial_bit_xform_if
// Request/result bundle for serial_bit_xform.
//   start  : request strobe (requester -> engine)
//   mode   : transform select, sampled with start
//   x      : WIDTH-bit operand, sampled with start
//   busy   : high while the engine is evaluating bits
//   done   : one-cycle pulse when y is updated
//   y      : WIDTH-bit result register
//   parity : XOR-reduce of y, only when XFORM_PARITY_EN is defined
// Modports: master = requester side, slave = engine side.
// ---------------------------------------------------------------------------
interface serial_bit_xform_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] x;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
`ifdef XFORM_PARITY_EN
  logic             parity;

  modport master (output start, mode, x, input busy, done, y, parity);
  modport slave  (input start, mode, x, output busy, done, y, parity);
`else
  modport master (output start, mode, x, input busy, done, y);
  modport slave  (input start, mode, x, output busy, done, y);
`endif

endinterface : serial_bit_xform_if

// File: rtl/xform_bit_slice.sv
// ---------------------------------------------------------------------------
// xform_bit_slice
// Combinational one-bit step of the selected transform.
//   mode      : transform select
//   x_bit     : operand bit x[i]
//   x_nb      : neighbour operand bit (x[i+1] for Gray encode, x[WIDTH-1-i]
//               for reverse)
//   w_prev    : previously produced result bit w[i+1] (Gray decode)
//   carry_in  : negate ripple carry into bit i
//   w_bit     : result bit w[i]
//   carry_out : negate ripple carry out of bit i
// ---------------------------------------------------------------------------
module xform_bit_slice
  import xform_pkg::*;
(
  input  xform_mode_e mode,
  input  logic        x_bit,
  input  logic        x_nb,
  input  logic        w_prev,
  input  logic        carry_in,
  output logic        w_bit,
  output logic        carry_out
);

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_bit     = 1'b0;
    carry_out = carry_in;
    case (mode)
      XF_BIN2GRAY: w_bit = x_bit ^ x_nb;
      XF_GRAY2BIN: w_bit = x_bit ^ w_prev;
      XF_REVERSE:  w_bit = x_nb;
      XF_NEGATE: begin
        // Invert-and-add-one, one bit at a time.
        w_bit     = ~x_bit ^ carry_in;
        carry_out = ~x_bit & carry_in;
      end
      default: w_bit = 1'b0;
    endcase
  end

endmodule : xform_bit_slice

// File: rtl/serial_bit_xform.sv
// ---------------------------------------------------------------------------
// serial_bit_xform
// Bit-serial transform engine: latches a WIDTH-bit operand on start and
// produces one result bit per clock (Gray encode, Gray decode, bit reverse
// or negate). Result appears in y with a one-cycle done pulse WIDTH+1
// cycles after start is sampled.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : serial_bit_xform_if slave (start/mode/x in, busy/done/y out)
// Optional: XFORM_PARITY_EN adds bus.parity = ^y, updated together with y.
// ---------------------------------------------------------------------------
module serial_bit_xform
  import xform_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  serial_bit_xform_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  xform_mode_e      mode_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] y_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;

  logic             load;
  logic             last_bit;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] idx_up;
  logic [CNT_W-1:0] idx_nb;
  logic [WIDTH:0]   x_ext;
  logic [WIDTH:0]   w_ext;
  logic [WIDTH-1:0] w_next;
  logic             x_nb;
  logic             w_bit;
  logic             carry_next;

  // -------------------------------------------------------------------------
  // Control FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    last_bit = (state_q == S_RUN) && (cnt_q == LAST);
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // start is deliberately ignored here; no request queueing.
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Bit index and neighbour selection
  // -------------------------------------------------------------------------
  // The operand and working registers are extended with a zero MSB so the
  // "bit above the top" reads as 0 for Gray encode/decode, and so every
  // index fits the counter width exactly.
  always_comb begin
    x_ext  = {1'b0, opnd_q};
    w_ext  = {1'b0, w_q};
    // Gray decode needs the higher result bit first, so it walks MSB-first.
    idx    = (mode_q == XF_GRAY2BIN) ? (LAST - cnt_q) : cnt_q;
    idx_up = idx + 1'b1;
    idx_nb = (mode_q == XF_REVERSE) ? (LAST - idx) : idx_up;
    x_nb   = x_ext[idx_nb];
  end

  xform_bit_slice u_slice (
    .mode      (mode_q),
    .x_bit     (x_ext[idx]),
    .x_nb      (x_nb),
    .w_prev    (w_ext[idx_up]),
    .carry_in  (carry_q),
    .w_bit     (w_bit),
    .carry_out (carry_next)
  );

  // Working register with the current bit merged in; y is loaded from this
  // on the last bit so it never exposes a partial result.
  always_comb begin
    w_next = w_q;
    for (int b = 0; b < WIDTH; b++) begin
      if (idx == CNT_W'(b)) w_next[b] = w_bit;
    end
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= XF_BIN2GRAY;
      opnd_q  <= '0;
      w_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
      if (load) begin
        opnd_q  <= bus.x;
        mode_q  <= xform_mode_e'(bus.mode);
        cnt_q   <= '0;
        carry_q <= 1'b1;
        w_q     <= '0;
      end else if (state_q == S_RUN) begin
        w_q     <= w_next;
        carry_q <= carry_next;
        // Wrap on the last bit so the counter always stays a legal index.
        cnt_q   <= last_bit ? '0 : cnt_q + 1'b1;
      end
      if (last_bit) y_q <= w_next;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.y    = y_q;

`ifdef XFORM_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (last_bit) begin
      parity_q <= ^w_next;
    end
  end

  assign bus.parity = parity_q;
`endif

endmodule : serial_bit_xform

// File: tb/tb_serial_bit_xform.sv
// ---------------------------------------------------------------------------
// tb_serial_bit_xform
// Self-checking bench for serial_bit_xform with WIDTH=8 and WIDTH=1 instances.
// Expected results come from a word-level reference function.
// Honours XFORM_PARITY_EN when defined.
// ---------------------------------------------------------------------------
module tb_serial_bit_xform;

  localparam int LIMIT = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  serial_bit_xform_if #(.WIDTH(8)) bus8 ();
  serial_bit_xform_if #(.WIDTH(1)) bus1 ();

  serial_bit_xform #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_bit_xform #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Word-level reference: arithmetic definitions of each transform.
  function automatic logic [63:0] ref_xform(input int w, input logic [1:0] m,
                                            input logic [63:0] v_in);
    logic [63:0] mask, v, r;
    logic        acc;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    v    = v_in & mask;
    r    = '0;
    case (m)
      2'd0: r = v ^ (v >> 1);
      2'd1: begin
        acc = 1'b0;
        for (int i = w - 1; i >= 0; i--) begin
          acc  = acc ^ v[i];
          r[i] = acc;
        end
      end
      2'd2: for (int i = 0; i < w; i++) r[i] = v[w-1-i];
      default: r = (~v + 64'd1) & mask;
    endcase
    return r & mask;
  endfunction

  // Issue one request on the 8-bit instance and wait for its done pulse.
  task automatic do_op8(input logic [1:0] m, input logic [7:0] v,
                        output logic [7:0] got, output int lat,
                        output int busy_n, output bit overlap);
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.mode = m; bus8.x = v;
    lat = 0; busy_n = 0; overlap = 1'b0;
    do begin
      @(posedge clk); #1;
      bus8.start = 1'b0;
      lat++;
      if (bus8.busy) busy_n++;
      if (bus8.busy && bus8.done) overlap = 1'b1;
    end while (!bus8.done && lat < LIMIT);
    got = bus8.y;
  endtask

  task automatic check_op8(input string name, input logic [1:0] m,
                           input logic [7:0] v);
    logic [7:0] got, exp;
    int lat, busy_n;
    bit overlap;
    exp = 8'(ref_xform(8, m, 64'(v)));
    do_op8(m, v, got, lat, busy_n, overlap);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s y: got=%b want=%b (mode=%0d x=%b)", name, got, exp, m, v);
    end
    total++;
    if (lat !== 9 || busy_n !== 8 || overlap) begin
      bad++;
      $display("FAIL %s timing: latency=%0d busy_cycles=%0d overlap=%0b want 9/8/0",
               name, lat, busy_n, overlap);
    end
`ifdef XFORM_PARITY_EN
    total++;
    if (bus8.parity !== ^exp) begin
      bad++;
      $display("FAIL %s parity: got=%b want=%b", name, bus8.parity, ^exp);
    end
`endif
  endtask

  task automatic test_reset;
    int stray;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    total++;
    if (bus8.y !== 8'h00 || bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: y=%h busy=%b done=%b want 00/0/0",
               bus8.y, bus8.busy, bus8.done);
    end
`ifdef XFORM_PARITY_EN
    total++;
    if (bus8.parity !== 1'b0) begin
      bad++;
      $display("FAIL reset_parity: got=%b want=0", bus8.parity);
    end
`endif
    stray = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus8.busy || bus8.done || bus1.busy || bus1.done) stray++;
    end
    total++;
    if (stray !== 0) begin
      bad++;
      $display("FAIL reset_idle: activity_cycles=%0d want 0", stray);
    end
  endtask

  task automatic test_directed;
    logic [7:0] held;
    check_op8("gray_enc", 2'd0, 8'b10101011);
    check_op8("gray_dec", 2'd1, 8'b10101011);
    held = bus8.y;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (bus8.y !== held || bus8.done !== 1'b0) begin
      bad++;
      $display("FAIL hold_y: y=%b done=%b want y=%b done=0", bus8.y, bus8.done, held);
    end
    check_op8("reverse", 2'd2, 8'b10101011);
    check_op8("negate", 2'd3, 8'b10101011);
    check_op8("negate_min", 2'd3, 8'h80);
    check_op8("negate_zero", 2'd3, 8'h00);
    check_op8("gray_enc_ff", 2'd0, 8'hFF);
    check_op8("gray_dec_top", 2'd1, 8'h80);
  endtask

  task automatic test_random;
    for (int k = 0; k < 24; k++) begin
      check_op8("random", 2'($urandom_range(3)), 8'($urandom));
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] ms[4];
    logic [7:0] xs[4];
    logic [7:0] exp;
    int n;
    for (int k = 0; k < 4; k++) begin
      ms[k] = 2'($urandom_range(3));
      xs[k] = 8'($urandom);
    end
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.mode = ms[0]; bus8.x = xs[0];
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!bus8.done && n < LIMIT);
      exp = 8'(ref_xform(8, ms[k], 64'(xs[k])));
      total++;
      if (n !== 9) begin
        bad++;
        $display("FAIL b2b_interval[%0d]: cycles=%0d want 9", k, n);
      end
      total++;
      if (bus8.y !== exp) begin
        bad++;
        $display("FAIL b2b_y[%0d]: got=%b want=%b", k, bus8.y, exp);
      end
      if (k < 3) begin
        bus8.mode = ms[k+1];
        bus8.x    = xs[k+1];
      end else begin
        bus8.start = 1'b0;
      end
    end
  endtask

  task automatic test_start_mid_run;
    logic [7:0] xa, exp;
    logic [1:0] ma;
    int n, stray;
    xa = 8'($urandom) | 8'h01;
    ma = 2'($urandom_range(3));
    exp = 8'(ref_xform(8, ma, 64'(xa)));
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.mode = ma; bus8.x = xa;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      bus8.start = (n == 3);
      if (n == 3) begin
        bus8.x    = ~xa;
        bus8.mode = ma + 2'd1;
      end
    end while (!bus8.done && n < LIMIT);
    total++;
    if (bus8.y !== exp || n !== 9) begin
      bad++;
      $display("FAIL mid_run_start: y=%b latency=%0d want y=%b latency=9", bus8.y, n, exp);
    end
    stray = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus8.done || bus8.busy || bus8.y !== exp) stray++;
    end
    total++;
    if (stray !== 0) begin
      bad++;
      $display("FAIL mid_run_ignored: disturbed_cycles=%0d want 0", stray);
    end
  endtask

  task automatic test_reset_mid_run;
    int stray;
    // Leave a known non-zero result in y first.
    check_op8("pre_reset", 2'd2, 8'h01);
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.mode = 2'd0; bus8.x = 8'h5A;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (bus8.y !== 8'h00 || bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
      bad++;
      $display("FAIL mid_run_reset: y=%h busy=%b done=%b want 00/0/0",
               bus8.y, bus8.busy, bus8.done);
    end
    stray = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus8.done || bus8.busy) stray++;
    end
    total++;
    if (stray !== 0) begin
      bad++;
      $display("FAIL mid_run_reset_quiet: activity_cycles=%0d want 0", stray);
    end
  endtask

  task automatic test_width1;
    logic [1:0] ms[6];
    logic       xs[6];
    logic       exp;
    int n;
    ms = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    xs = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 6; k++) begin
      exp = ref_xform(1, ms[k], 64'(xs[k]))[0];
      @(posedge clk); #1;
      bus1.start = 1'b1; bus1.mode = ms[k]; bus1.x = xs[k];
      n = 0;
      do begin
        @(posedge clk); #1;
        bus1.start = 1'b0;
        n++;
      end while (!bus1.done && n < LIMIT);
      total++;
      if (bus1.y[0] !== exp || n !== 2) begin
        bad++;
        $display("FAIL width1[%0d]: y=%b latency=%0d want y=%b latency=2 (mode=%0d x=%b)",
                 k, bus1.y[0], n, exp, ms[k], xs[k]);
      end
    end
  endtask

  initial begin
    bus8.start = 1'b0; bus8.mode = 2'd0; bus8.x = '0;
    bus1.start = 1'b0; bus1.mode = 2'd0; bus1.x = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_start_mid_run();
    test_reset_mid_run();
    test_width1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_serial_bit_xform
